// File: rtl/dpr_collision_ctrl_if.sv
// Requester/RAM bus bundle for dpr_collision_ctrl.
// Carries both requester ports (A, B) and both RAM ports (0, 1).
//   master : client side, which also hosts the RAM that returns ram_dout_*.
//   slave  : the collision controller itself.
interface dpr_collision_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 12
);

  // Requester A
  logic          a_req;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt;
  logic [DW-1:0] a_rdata;
  logic          a_rvalid;

  // Requester B
  logic          b_req;
  logic          b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt;
  logic [DW-1:0] b_rdata;
  logic          b_rvalid;

  // RAM port 0 (serves A)
  logic          ram_we_0;
  logic [AW-1:0] ram_addr_0;
  logic [DW-1:0] ram_din_0;
  logic [DW-1:0] ram_dout_0;

  // RAM port 1 (serves B)
  logic          ram_we_1;
  logic [AW-1:0] ram_addr_1;
  logic [DW-1:0] ram_din_1;
  logic [DW-1:0] ram_dout_1;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rdata, a_rvalid,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rdata, b_rvalid,
    input  ram_we_0, ram_addr_0, ram_din_0,
    output ram_dout_0,
    input  ram_we_1, ram_addr_1, ram_din_1,
    output ram_dout_1
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rdata, a_rvalid,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rdata, b_rvalid,
    output ram_we_0, ram_addr_0, ram_din_0,
    input  ram_dout_0,
    output ram_we_1, ram_addr_1, ram_din_1,
    input  ram_dout_1
  );

endinterface

// File: rtl/dpr_collision_ctrl.sv
// Dual-port RAM front-end collision controller.
// Requester A drives RAM port 0, requester B drives RAM port 1. A same-address
// access pair in which at least one side writes is a collision; only the side
// selected by the alternating priority pointer is granted, and the pointer
// flips so the loser is served on the following cycle (wait <= 1 cycle).
// Read data is a pass-through of the RAM's registered output, qualified by a
// registered rvalid strobe one cycle after the read grant.
// Optional build macro DPR_COLL_STATS_EN adds a saturating 16-bit collision
// counter (coll_cnt) and a sticky collision flag (coll_seen).
module dpr_collision_ctrl #(
  parameter int DW = 8,
  parameter int AW = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dpr_collision_ctrl_if.slave  bus
`ifdef DPR_COLL_STATS_EN
  ,
  output logic [15:0]          coll_cnt,
  output logic                 coll_seen
`endif
);

  // Priority pointer: which requester wins the next collision.
  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  pri_e          pri_q, pri_d;

  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          same_addr;
  logic          any_write;
  logic          collision;
  logic          a_gnt, b_gnt;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;

  assign a_addr    = bus.a_addr;
  assign b_addr    = bus.b_addr;
  assign a_wdata   = bus.a_wdata;
  assign b_wdata   = bus.b_wdata;

  // Two reads of one address are harmless; only a write makes it a conflict.
  assign same_addr = (a_addr == b_addr);
  assign any_write = bus.a_we | bus.b_we;
  assign collision = bus.a_req & bus.b_req & same_addr & any_write;

  // Grant decision, pointer advance and read-valid next state.
  always_comb begin
    pri_d      = pri_q;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    if (rst_n) begin
      a_gnt = bus.a_req & ~(collision & (pri_q == PRI_B));
      b_gnt = bus.b_req & ~(collision & (pri_q == PRI_A));
      if (collision) begin
        pri_d = (pri_q == PRI_A) ? PRI_B : PRI_A;
      end
      a_rvalid_d = a_gnt & ~bus.a_we;
      b_rvalid_d = b_gnt & ~bus.b_we;
    end
  end

  // Priority pointer register; A wins the first collision after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pri_q <= PRI_A;
    end else begin
      pri_q <= pri_d;
    end
  end

  // Read-valid strobes; a read granted just before reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // Address/data follow the requester; only a granted port may write.
  assign bus.ram_addr_0 = a_addr;
  assign bus.ram_din_0  = a_wdata;
  assign bus.ram_we_0   = a_gnt & bus.a_we;
  assign bus.ram_addr_1 = b_addr;
  assign bus.ram_din_1  = b_wdata;
  assign bus.ram_we_1   = b_gnt & bus.b_we;

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rdata  = bus.ram_dout_0;
  assign bus.b_rdata  = bus.ram_dout_1;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;

`ifdef DPR_COLL_STATS_EN
  logic [15:0] coll_cnt_q, coll_cnt_d;
  logic        coll_seen_q, coll_seen_d;

  // Saturating collision count and sticky first-collision flag.
  always_comb begin
    coll_cnt_d  = coll_cnt_q;
    coll_seen_d = coll_seen_q;
    if (collision) begin
      coll_seen_d = 1'b1;
      if (coll_cnt_q != 16'hFFFF) begin
        coll_cnt_d = coll_cnt_q + 16'd1;
      end
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coll_cnt_q  <= 16'd0;
      coll_seen_q <= 1'b0;
    end else begin
      coll_cnt_q  <= coll_cnt_d;
      coll_seen_q <= coll_seen_d;
    end
  end

  assign coll_cnt  = coll_cnt_q;
  assign coll_seen = coll_seen_q;
`endif

endmodule

// File: doc/dpr_collision_ctrl.md
Name: dpr_collision_ctrl

Overview:
- Front-end controller for the 8-bit x 4096 true dual-port RAM. It connects two independent requesters (A, B) to RAM port 0 and port 1.
- It detects same-address collisions in which at least one side writes, and serialises them with an alternating-priority pointer so the RAM never sees conflicting same-cycle accesses.
- It returns read data with a registered valid strobe.
- Instantiated between client logic and the RAM, which stays external.

Parameters:
- DW, 8, data width.
- AW, 12, address width (RAM depth 2**AW).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- a_req  in  1  requester A access request; held until granted.
- a_we  in  1  A write (1) / read (0).
- a_addr  in  AW  A address.
- a_wdata  in  DW  A write data.
- a_gnt  out  1  A request issued to RAM this cycle.
- a_rdata  out  DW  A read data (pass-through of ram_dout_0).
- a_rvalid  out  1  a_rdata valid.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rdata, b_rvalid: same as A, mapped to RAM port 1.
- ram_we_0  out  1  RAM port 0 write enable.
- ram_addr_0  out  AW  RAM port 0 address.
- ram_din_0  out  DW  RAM port 0 write data.
- ram_dout_0  in  DW  RAM port 0 registered read data.
- ram_we_1, ram_addr_1, ram_din_1, ram_dout_1: same for RAM port 1.

Behaviour:
- Clocking: single clock clk; rst_n is synchronous and active-low. Every register updates only on the rising edge of clk.
- Collision is a combinational term: a_req & b_req & (a_addr==b_addr) & (a_we|b_we). Two reads of the same address are not a collision; both are granted.
- Priority register pri (0 = A wins, 1 = B wins):
  - On a collision only the winner is granted.
  - pri toggles at the clock edge ending every collision cycle, so the loser wins the next cycle.
  - Maximum wait for a held request is 1 cycle.
  - pri is unchanged on non-collision cycles.
- Grant is combinational in the issue cycle:
  - a_gnt = rst_n & a_req & ~(collision & pri).
  - b_gnt = rst_n & b_req & ~(collision & ~pri).
- RAM drive:
  - ram_addr_x and ram_din_x follow the requester's addr and wdata unconditionally.
  - ram_we_x = x_gnt & x_we. An ungranted port never writes.
- Read latency:
  - x_rvalid is registered: x_rvalid <= x_gnt & ~x_we.
  - It is high the cycle after the grant; x_rdata = ram_dout_x is valid in that cycle.
  - No rvalid is produced for writes.
- Write-write collision on the same address: the winner writes first and the loser writes next cycle, so the loser's data persists.
- Write-read collision: the order follows pri.
  - If the reader wins, it returns the old data.
  - If the writer wins, the reader is issued next cycle and returns the new data.
- Back-to-back: a requester may hold req high across cycles. Each granted cycle is one transaction; the requester must change addr, we and wdata only after the gnt cycle.
- Reset (rst_n low at an edge, including mid-transaction):
  - pri <= 0, a_rvalid <= 0, b_rvalid <= 0.
  - Grants are forced 0 while rst_n is low, so ram_we_0 and ram_we_1 are 0 during reset.
  - A read granted in the cycle before reset asserts does not produce rvalid.

Optional Feature:
- Macro DPR_COLL_STATS_EN.
- When defined:
  - Adds output coll_cnt (16 bits) counting collision cycles.
  - Adds output coll_seen (1 bit), sticky-set on the first collision.
  - Both reset to 0 on rst_n low.
  - coll_cnt saturates at 16'hFFFF; it does not wrap.
- When undefined: neither port nor any counter logic exists, and behaviour is otherwise identical.

Test Plan:
- Reset, then A writes 8'hA5 @12'h010 and B writes 8'h3C @12'h020 in the same cycle -> both gnt=1 that cycle; next cycle A reads 010 and B reads 020 -> the cycle after, a_rvalid=b_rvalid=1, a_rdata=A5, b_rdata=3C.
- After reset (pri=0), A writes 8'h11 and B writes 8'h22, both @12'h100, held -> cycle0: a_gnt=1, b_gnt=0; cycle1: b_gnt=1; then a read of 100 returns 8'h22.
- pri=1, A writes 8'h55 @12'h200 (old value 8'h00) and B reads 12'h200 -> B granted first, b_rdata=00; A granted next cycle; a follow-up B read returns 55.
- A and B both read 12'hFFF (holding 8'h7E) in the same cycle -> both gnt=1, no collision, pri unchanged, both rdata=7E with rvalid one cycle later.
- A read granted, rst_n driven low the next edge -> a_rvalid=0, pri=0, no RAM write while in reset.
- With DPR_COLL_STATS_EN: 3 collision cycles -> coll_cnt=3, coll_seen=1; after reset both 0; force 65537 collisions -> coll_cnt=16'hFFFF.
